txfifo: RTL

- Transmit-side FIFO of the synchronous serial port (SSP). It is the counterpart of the receive FIFO.
- It accepts bytes written by the APB host (PSEL with PWRITE) and buffers up to DEPTH of them.
- It presents the head byte first-word-fall-through to the transmit shift logic, which consumes bytes with a one-cycle pop strobe.
- It raises SSPTXINTR while full so the host stops writing.

---
 rtl/ssp_pkg.sv | 7 +
 rtl/txfifo.sv | 81 ++++++++
 2 files changed

// File: rtl/ssp_pkg.sv
// Constants and types shared by the SSP transmit/receive FIFOs and shift logic.
package ssp_pkg;
  localparam int SSP_DATA_W     = 8;
  localparam int SSP_FIFO_DEPTH = 4;

  typedef logic [SSP_DATA_W-1:0] ssp_byte_t;
endpackage

// File: rtl/txfifo.sv
// SSP transmit FIFO: APB writes enqueue bytes, the tx shift logic pops them.
// Head byte is presented first-word-fall-through; SSPTXINTR flags full.
module txfifo
  import ssp_pkg::*;
#(
  parameter  int DEPTH = SSP_FIFO_DEPTH,
  parameter  int WIDTH = SSP_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             PCLK,
  input  logic             CLEAR,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  input  logic             tx_pop,
  output logic [WIDTH-1:0] TxData,
  output logic             tx_valid,
  output logic             SSPTXINTR,
  output logic             tx_overflow
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             overflow;

  logic full;
  logic empty;
  logic wr_req;
  logic wr_en;
  logic rd_en;

  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign wr_req = PSEL & PWRITE;
  // A full FIFO drops the write even if a pop frees a slot this cycle.
  assign wr_en  = wr_req & ~full;
  assign rd_en  = tx_pop & ~empty;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of order.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      // NOTE: storage is cleared as well, so TxData is a defined 0 after
      // CLEAR instead of showing whatever byte was left behind.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= PWDATA;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_req & full) begin
        overflow <= 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  assign TxData      = mem[rd_ptr];
  assign tx_valid    = ~empty;
  assign SSPTXINTR   = full;
  assign tx_overflow = overflow;

endmodule
